serial_subtractor: RTL
======================

// Module: serial_subtractor
// PURPOSE
//  Bit-serial WIDTH-bit subtractor: diff = a - b - bin, processed LSB first, one bit per clock.
//  Each bit goes through a single full-subtractor cell with a registered borrow. This is the
//  inverse-direction companion to the team's full-adder datapath.
//  Used where area matters more than latency (e.g. decrement/compare paths in slow control logic).
//  Start/done handshake; the result is held stable until the next accepted start.
// PARAMETERS
//  WIDTH   8   operand/result width in bits (>=2)
// PORTS
//  clk     in   1      single clock, all state updates on rising edge
//  rst     in   1      synchronous, active-high reset
//  start   in   1      request; sampled only when busy==0
//  a       in   WIDTH  minuend, captured on accepted start
//  b       in   WIDTH  subtrahend, captured on accepted start
//  bin     in   1      borrow-in, captured on accepted start
//  busy    out  1      high while an operation is in progress (RUN state)
//  done    out  1      one-cycle pulse: diff/bout valid and newly updated
//  diff    out  WIDTH  result a-b-bin mod 2^WIDTH, held until the next completion
//  bout    out  1      borrow-out: 1 iff a < b+bin (unsigned)
// BEHAVIOUR
//  Reset (rst=1 at an edge): state=IDLE, busy=0, done=0, diff=0, bout=0, bit counter=0.
//   - Reset overrides everything, including start and mid-operation state.
//   - A partial result is discarded, never presented.
//  States: IDLE -> RUN -> DONE -> IDLE (or DONE -> RUN).
//   - IDLE: start=1 at an edge -> capture a,b into shift regs, borrow reg<=bin, cnt<=0, go RUN.
//   - RUN: each edge takes ai=a_sh[0], bi=b_sh[0], br=borrow reg, then updates:
//       d = ai^bi^br
//       br' = (~ai&bi) | (~(ai^bi)&br)
//       shift d into result reg MSB side; shift a_sh and b_sh right; cnt<=cnt+1.
//     On the edge processing bit WIDTH-1: diff<=final result, bout<=br', done<=1, go DONE.
//   - DONE: done=1 for exactly this cycle; busy=0.
//       start=1 -> accepted (back-to-back), go RUN.
//       otherwise go IDLE.
//  Latency: start sampled at edge N -> done=1 during the cycle after edge N+WIDTH.
//   - Throughput: one result per WIDTH+1 cycles.
//  busy=1 exactly in RUN (WIDTH cycles). start while busy=1 is ignored and never queued.
//  Operand inputs are don't-care except in the cycle start is accepted.
//  diff/bout change only on the completing edge or on reset, never mid-operation.
//  Counter width: $clog2(WIDTH); terminal compare cnt==WIDTH-1. No wrap-around beyond that.
// STRUCTURE
//  Shared package: state encoding localparams (S_IDLE, S_RUN, S_DONE) for 2-bit state.
//  Sub-module: full_subtractor (combinational)
//   - ports: a, b, bin -> diff, bout
//   - instantiated once in the bit-slice path; same port style as full_adder.
//  Top: FSM, counter, two operand shift regs, result shift reg, borrow flop, output regs.
// TESTING (WIDTH=8 unless noted)
//  1. a=5, b=3, bin=0, start 1 cycle -> done after 9 cycles; diff=2, bout=0; busy high 8 cycles.
//  2. a=3, b=5, bin=0 -> diff=254, bout=1. Then a=0, b=0, bin=1 -> diff=255, bout=1.
//  3. a=255, b=255, bin=0 -> diff=0, bout=0. Pulse start=1 during RUN with a=1, b=0:
//     must be ignored; exactly one done, result unchanged.
//  4. Hold start=1 continuously with new operands at each done cycle:
//     back-to-back done every 9 cycles, each with correct result.
//  5. Assert rst at cycle 4 of RUN -> next cycle busy=0, done=0, diff=0, bout=0;
//     no done follows; a fresh start then works.
//  6. WIDTH=4: exhaustive a,b in 0..15, bin in 0..1 vs reference (a-b-bin) mod 16
//     and bout=(a<b+bin); $monitor-log each done.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding.
package serial_subtractor_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor cell (combinational): diff = a - b - bin.
module full_subtractor
  import serial_subtractor_pkg::*;
(
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_diff,
  output logic o_bout
);
  assign o_diff = i_a ^ i_b ^ i_bin;
  assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first; done pulses WIDTH cycles after the accepted start.
// start is only sampled when not busy; results hold until the next completion or reset.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_bin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_bout
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_diff;
  logic             r_br;
  logic             r_bout;
  logic             r_busy;
  logic             r_done;
  logic             w_d;
  logic             w_br;

  full_subtractor u_fs (
    .i_a   (r_a_sh[0]),
    .i_b   (r_b_sh[0]),
    .i_bin (r_br),
    .o_diff(w_d),
    .o_bout(w_br)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_res   <= '0;
      r_diff  <= '0;
      r_br    <= 1'b0;
      r_bout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_a_sh  <= i_a;
            r_b_sh  <= i_b;
            r_br    <= i_bin;
            r_res   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          // Result bits enter at the MSB so bit 0 lands at position 0 after WIDTH shifts.
          r_a_sh <= r_a_sh >> 1;
          r_b_sh <= r_b_sh >> 1;
          r_res  <= {w_d, r_res[WIDTH-1:1]};
          r_br   <= w_br;
          r_cnt  <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_diff  <= {w_d, r_res[WIDTH-1:1]};
            r_bout  <= w_br;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_diff = r_diff;
  assign o_bout = r_bout;
endmodule
